rs_syndrome_stream: RTL and testbench

- Parametrised, streaming RS(N,K) syndrome calculator over GF(2^SYM_W); successor of the fixed 22-lane, zero-latency M=32 syndrome unit.
- Accepts M symbols per beat with a valid/ready handshake. Supports codeword lengths that are not a multiple of M through an implicit partial first beat.
- Registers the J=N-K syndromes, a zero flag and a framing-error flag, and holds them under output backpressure. Sits between the deinterleaver and the key-equation solver.

---
 rtl/rs_syndrome_stream_if.sv | 29 ++
 rtl/rs_syndrome_stream.sv | 225 ++++++++++++++++++++++
 tb/tb_rs_syndrome_stream.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_syndrome_stream_if.sv
// Stream bundle for rs_syndrome_stream: input beat channel (valid/ready,
// start/last framing, M symbols) and result channel (valid/ready, J
// syndromes, zero and framing-error flags).
interface rs_syndrome_stream_if #(
  parameter int M     = 32,
  parameter int SYM_W = 10,
  parameter int J     = 22
);
  logic                 valid_i;
  logic                 ready_o;
  logic                 start_i;
  logic                 last_i;
  logic [M*SYM_W-1:0]   data_i;
  logic                 s_valid_o;
  logic                 s_ready_i;
  logic [J*SYM_W-1:0]   s_o;
  logic                 s_zero_o;
  logic                 frame_err_o;

  modport slave (
    input  valid_i, start_i, last_i, data_i, s_ready_i,
    output ready_o, s_valid_o, s_o, s_zero_o, frame_err_o
  );

  modport master (
    output valid_i, start_i, last_i, data_i, s_ready_i,
    input  ready_o, s_valid_o, s_o, s_zero_o, frame_err_o
  );
endinterface

// File: rtl/rs_syndrome_stream.sv
// Streaming RS(N,K) syndrome calculator over GF(2^SYM_W).
// M symbols per beat, Horner update per syndrome, partial first beat when
// N is not a multiple of M (upper lanes of the start beat are ignored).
// Optional macro RS_SYND_PIPE_EN registers the per-beat XOR sum, giving a
// result latency of 2 instead of 1; syndrome values are identical.
module rs_syndrome_stream #(
  parameter int          N         = 544,
  parameter int          K         = 522,
  parameter int          M         = 32,
  parameter int          SYM_W     = 10,
  parameter logic [31:0] PRIM_POLY = 32'h409,
  parameter int          FCR       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rs_syndrome_stream_if.slave   bus
);

  localparam int J     = N - K;
  localparam int BEATS = (N + M - 1) / M;
  localparam int R     = N - (BEATS - 1) * M;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ORDER = (1 << SYM_W) - 1;
  localparam logic [SYM_W-1:0] POLY_LO = PRIM_POLY[SYM_W-1:0];

  // GF(2^SYM_W) multiply; with one constant operand this folds to XORs.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
    end
    return p;
  endfunction

  // alpha^e by square-and-multiply, used only for elaboration constants.
  function automatic logic [SYM_W-1:0] gf_alpha_pow(input int e);
    logic [SYM_W-1:0] r;
    logic [SYM_W-1:0] b;
    int               k;
    r = SYM_W'(1);
    b = SYM_W'(2);
    k = e % ORDER;
    for (int i = 0; i < 31; i++) begin
      if (((k >> i) & 1) != 0) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 err_pend;

  logic [J*SYM_W-1:0]   acc_q;
  logic [J*SYM_W-1:0]   acc_new;
  logic                 s_valid_q;
  logic [J*SYM_W-1:0]   s_q;
  logic                 s_zero_q;
  logic                 frame_err_q;

  // ---- stage p0: framing decisions, lane masking, per-beat XOR sum ----
  logic [M*SYM_W-1:0]   lane_p0;
  logic [J*SYM_W-1:0]   sum_p0;
  logic                 in_frame_p0;
  logic [CNT_W-1:0]     cnt_now_p0;
  logic                 at_end_p0;
  logic                 cmpl_p0;
  logic                 err_eff_p0;
  logic                 err_p0;
  logic                 hold_p0;
  logic                 ready_p0;
  logic                 acc_p0;
  logic                 vld_p0;

  for (genvar m = 0; m < M; m++) begin : g_lane
    if (m >= R) begin : g_hi
      assign lane_p0[m*SYM_W +: SYM_W] = bus.start_i ? '0 : bus.data_i[m*SYM_W +: SYM_W];
    end else begin : g_lo
      assign lane_p0[m*SYM_W +: SYM_W] = bus.data_i[m*SYM_W +: SYM_W];
    end
  end

  for (genvar j = 0; j < J; j++) begin : g_sum
    logic [M*SYM_W-1:0] prod;
    logic [SYM_W-1:0]   sum_j;
    for (genvar m = 0; m < M; m++) begin : g_prod
      localparam logic [SYM_W-1:0] C = gf_alpha_pow((FCR + j) * m);
      assign prod[m*SYM_W +: SYM_W] = gf_mul(lane_p0[m*SYM_W +: SYM_W], C);
    end
    // XOR all lane products of this syndrome.
    always_comb begin
      sum_j = '0;
      for (int m = 0; m < M; m++) sum_j = sum_j ^ prod[m*SYM_W +: SYM_W];
    end
    assign sum_p0[j*SYM_W +: SYM_W] = sum_j;
  end

  assign in_frame_p0 = bus.start_i || (state == ACC);
  assign cnt_now_p0  = bus.start_i ? '0 : beat_cnt;
  assign at_end_p0   = (cnt_now_p0 == CNT_W'(BEATS - 1));
  assign cmpl_p0     = in_frame_p0 && (bus.last_i || at_end_p0);
  assign err_eff_p0  = err_pend || (bus.start_i && (state == ACC));
  assign err_p0      = err_eff_p0 || !at_end_p0 || !bus.last_i;
  assign hold_p0     = s_valid_q && !bus.s_ready_i;
  assign acc_p0      = bus.valid_i && ready_p0;
  assign vld_p0      = acc_p0 && in_frame_p0;
  assign bus.ready_o = ready_p0;

  // Frame tracking: start detection, beat counting, pending framing error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      err_pend <= 1'b0;
    end else if (acc_p0) begin
      if (!in_frame_p0) begin
        err_pend <= 1'b1;
      end else if (cmpl_p0) begin
        state    <= IDLE;
        beat_cnt <= '0;
        err_pend <= 1'b0;
      end else begin
        state    <= ACC;
        beat_cnt <= cnt_now_p0 + 1'b1;
        err_pend <= err_eff_p0;
      end
    end
  end

  logic                 upd_vld;
  logic                 upd_start;
  logic                 upd_cmpl;
  logic                 upd_err;
  logic [J*SYM_W-1:0]   upd_sum;

`ifdef RS_SYND_PIPE_EN
  // ---- stage p1: registered sum and its control flags ----
  logic                 vld_p1;
  logic                 start_p1;
  logic                 cmpl_p1;
  logic                 err_p1;
  logic [J*SYM_W-1:0]   sum_p1;

  // A completion in flight will occupy the result register next cycle.
  assign ready_p0 = !(bus.valid_i && cmpl_p0 && (hold_p0 || cmpl_p1));

  // Control flags travelling with the registered sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      start_p1 <= 1'b0;
      cmpl_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      start_p1 <= bus.start_i;
      cmpl_p1  <= vld_p0 && cmpl_p0;
      err_p1   <= err_p0;
    end
  end

  // Registered XOR sum (data path, not reset).
  always_ff @(posedge clk_i) begin
    if (vld_p0) sum_p1 <= sum_p0;
  end

  assign upd_vld   = vld_p1;
  assign upd_start = start_p1;
  assign upd_cmpl  = cmpl_p1;
  assign upd_err   = err_p1;
  assign upd_sum   = sum_p1;
`else
  assign ready_p0  = !(bus.valid_i && cmpl_p0 && hold_p0);
  assign upd_vld   = vld_p0;
  assign upd_start = bus.start_i;
  assign upd_cmpl  = vld_p0 && cmpl_p0;
  assign upd_err   = err_p0;
  assign upd_sum   = sum_p0;
`endif

  // ---- update stage: Horner step acc*alpha^(e*M) xor beat sum ----
  for (genvar j = 0; j < J; j++) begin : g_horner
    localparam logic [SYM_W-1:0] FB = gf_alpha_pow((FCR + j) * M);
    logic [SYM_W-1:0] fb;
    assign fb = gf_mul(acc_q[j*SYM_W +: SYM_W], FB);
    assign acc_new[j*SYM_W +: SYM_W] = upd_start ? upd_sum[j*SYM_W +: SYM_W]
                                                 : (fb ^ upd_sum[j*SYM_W +: SYM_W]);
  end

  // Syndrome accumulators.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        acc_q <= '0;
    else if (upd_vld) acc_q <= acc_new;
  end

  // Result register: load on completion, hold under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_valid_q   <= 1'b0;
      s_q         <= '0;
      s_zero_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (upd_cmpl) begin
      s_valid_q   <= 1'b1;
      s_q         <= acc_new;
      s_zero_q    <= (acc_new == '0);
      frame_err_q <= upd_err;
    end else if (s_valid_q && bus.s_ready_i) begin
      s_valid_q   <= 1'b0;
    end
  end

  assign bus.s_valid_o   = s_valid_q;
  assign bus.s_o         = s_q;
  assign bus.s_zero_o    = s_zero_q;
  assign bus.frame_err_o = frame_err_q;

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed bench for rs_syndrome_stream: default RS(544,522) M=32 instance
// plus an N=100 instance exercising the partial first beat.
module tb_rs_syndrome_stream;

`ifdef RS_SYND_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errs;

  logic [9:0]   cw [544];
  logic [219:0] ev;

  rs_syndrome_stream_if #(.M(32), .SYM_W(10), .J(22)) ifa ();
  rs_syndrome_stream_if #(.M(32), .SYM_W(10), .J(22)) ifb ();

  rs_syndrome_stream #(.N(544), .K(522), .M(32), .SYM_W(10)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  rs_syndrome_stream #(.N(100), .K(78), .M(32), .SYM_W(10)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // alpha^e by repeated multiply-by-x in GF(2^10), x^10 = x^3 + 1.
  function automatic logic [9:0] xpow(input int e);
    logic [9:0] v;
    v = 10'd1;
    for (int i = 0; i < (e % 1023); i++) v = v[9] ? ((v << 1) ^ 10'h009) : (v << 1);
    return v;
  endfunction

  // Syndromes of a single unit symbol at degree deg: S_j = alpha^(deg*j).
  function automatic logic [219:0] exp_vec(input int deg);
    logic [219:0] v;
    v = '0;
    for (int j = 1; j <= 22; j++) v[(j-1)*10 +: 10] = xpow(deg * j);
    return v;
  endfunction

  task automatic clear_cw();
    for (int i = 0; i < 544; i++) cw[i] = 10'h000;
  endtask

  task automatic drive_a(input int b, input bit st, input bit ls);
    for (int m = 0; m < 32; m++) ifa.data_i[m*10 +: 10] = cw[(16-b)*32 + m];
    ifa.valid_i = 1'b1;
    ifa.start_i = st;
    ifa.last_i  = ls;
  endtask

  // Send beats 0..nb-1 of cw on dut_a; last_i on beat last_b.
  task automatic send_a(input int nb, input int last_b, input int max_stall,
                        output int stalls, output bit done, output int vhigh);
    logic r;
    bit   ok;
    stalls = 0;
    done   = 1'b1;
    vhigh  = 0;
    for (int b = 0; b < nb; b++) begin
      ok = 1'b0;
      while (!ok) begin
        drive_a(b, (b == 0), (b == last_b));
        #1;
        r = ifa.ready_o;
        if (ifa.s_valid_o) vhigh++;
        @(posedge clk);
        @(negedge clk);
        if (r) ok = 1'b1;
        else begin
          stalls++;
          if (stalls > max_stall) begin
            done = 1'b0;
            return;
          end
        end
      end
    end
    ifa.valid_i = 1'b0;
    ifa.start_i = 1'b0;
    ifa.last_i  = 1'b0;
  endtask

  task automatic expect_a(input string tag, input logic [219:0] es, input bit ez, input bit ee);
    for (int k = 1; k < LAT; k++) begin
      chk({tag, "_early"}, ifa.s_valid_o, 0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, ifa.s_valid_o, 1);
    chk({tag, "_s"}, ifa.s_o, es);
    chk({tag, "_zero"}, ifa.s_zero_o, ez);
    chk({tag, "_err"}, ifa.frame_err_o, ee);
  endtask

  initial begin
    int st;
    bit dn;
    int vh;
    checks = 0;
    errs   = 0;
    rst = 1'b1;
    ifa.valid_i = 0; ifa.start_i = 0; ifa.last_i = 0; ifa.data_i = '0; ifa.s_ready_i = 1;
    ifb.valid_i = 0; ifb.start_i = 0; ifb.last_i = 0; ifb.data_i = '0; ifb.s_ready_i = 1;
    clear_cw();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ifa.s_valid_o, 0);
    chk("rst_ready", ifa.ready_o, 1);
    chk("rst_s", ifa.s_o, 0);
    chk("rst_zero", ifa.s_zero_o, 0);
    chk("rst_err", ifa.frame_err_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero codeword.
    send_a(17, 16, 2, st, dn, vh);
    chk("zero_done", dn, 1);
    expect_a("zero", '0, 1, 0);
    @(negedge clk);
    chk("zero_clear", ifa.s_valid_o, 0);

    // codeword[0] = 1 -> every S_j = 1.
    cw[0] = 10'h001;
    send_a(17, 16, 2, st, dn, vh);
    expect_a("deg0", exp_vec(0), 0, 0);
    @(negedge clk);

    // codeword[1] = 1 -> S_j = alpha^j.
    clear_cw();
    cw[1] = 10'h001;
    send_a(17, 16, 2, st, dn, vh);
    expect_a("deg1", exp_vec(1), 0, 0);
    chk("deg1_s1", ifa.s_o[9:0], 10'h002);
    chk("deg1_s2", ifa.s_o[19:10], 10'h004);
    chk("deg1_s10", ifa.s_o[99:90], 10'h009);
    @(negedge clk);

    // N=100 partial first beat: garbage in lanes 31..4, codeword[99] in lane 3.
    for (int b = 0; b < 4; b++) begin
      ifb.data_i = '0;
      if (b == 0) begin
        for (int m = 4; m < 32; m++) ifb.data_i[m*10 +: 10] = 10'h3FF;
        ifb.data_i[39:30] = 10'h001;
      end
      ifb.valid_i = 1'b1;
      ifb.start_i = (b == 0);
      ifb.last_i  = (b == 3);
      #1;
      chk("b_ready", ifb.ready_o, 1);
      @(posedge clk);
      @(negedge clk);
    end
    ifb.valid_i = 0; ifb.start_i = 0; ifb.last_i = 0;
    for (int k = 1; k < LAT; k++) begin
      chk("b_early", ifb.s_valid_o, 0);
      @(negedge clk);
    end
    chk("b_valid", ifb.s_valid_o, 1);
    chk("b_s", ifb.s_o, exp_vec(99));
    chk("b_zero", ifb.s_zero_o, 0);
    chk("b_err", ifb.frame_err_o, 0);
    @(negedge clk);

    // Backpressure: two back-to-back frames with the result held.
    ifa.s_ready_i = 1'b0;
    clear_cw();
    cw[0] = 10'h001;
    send_a(17, 16, 2, st, dn, vh);
    chk("bp_f1_done", dn, 1);
    clear_cw();
    cw[1] = 10'h001;
    send_a(16, -1, 0, st, dn, vh);
    chk("bp_f2_body", dn, 1);
    drive_a(16, 1'b0, 1'b1);
    #1;
    chk("bp_rdy_low", ifa.ready_o, 0);
    chk("bp_hold_v", ifa.s_valid_o, 1);
    chk("bp_hold_s", ifa.s_o, exp_vec(0));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_rdy_low2", ifa.ready_o, 0);
    chk("bp_hold_s2", ifa.s_o, exp_vec(0));
    @(negedge clk);
    ifa.s_ready_i = 1'b1;
    #1;
    chk("bp_rdy_rel", ifa.ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    ifa.valid_i = 0; ifa.start_i = 0; ifa.last_i = 0;
    expect_a("bp_f2", exp_vec(1), 0, 0);
    @(negedge clk);

    // Early last on beat 10 of 17, then a clean frame.
    clear_cw();
    send_a(10, 9, 2, st, dn, vh);
    expect_a("early", '0, 1, 1);
    @(negedge clk);
    send_a(17, 16, 2, st, dn, vh);
    expect_a("clean", '0, 1, 0);
    @(negedge clk);

    // Reset mid-frame while a result is held, then a single-error frame.
    ifa.s_ready_i = 1'b0;
    send_a(17, 16, 2, st, dn, vh);
    send_a(8, -1, 0, st, dn, vh);
    chk("rst_pre_v", ifa.s_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_v", ifa.s_valid_o, 0);
    chk("rst_mid_rdy", ifa.ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    ifa.s_ready_i = 1'b1;
    @(negedge clk);
    cw[1] = 10'h001;
    send_a(17, 16, 2, st, dn, vh);
    chk("rst_f_done", dn, 1);
    chk("rst_f_vlow", vh, 0);
    expect_a("rst_f", exp_vec(1), 0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
